// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: writeback result selects and load sizes.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  // Result source for the writeback mux; encoding 3 is reserved.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_e;

  // Load access size; encoding 3 is reserved and behaves as a word.
  typedef enum logic [1:0] {
    LS_B = 2'd0,
    LS_H = 2'd1,
    LS_W = 2'd2
  } load_size_e;

endpackage

// File: rtl/rv32_load_align.sv
// Load alignment: picks the byte/halfword addressed by offset from the raw
// data-memory word and sign- or zero-extends it.
// Ports:
//   raw       raw aligned data-memory word
//   offset    low address bits of the effective address
//   size      load size (load_size_e)
//   zero_ext  1 = zero-extend (LBU/LHU), 0 = sign-extend
//   data      extended load result (combinational)
module rv32_load_align
  import rv32_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] raw,
  input  logic [1:0]            offset,
  input  logic [1:0]            size,
  input  logic                  zero_ext,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select within the 32-bit word.
  always_comb begin
    byte_sel = raw[7:0];
    case (offset)
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      2'd3:    byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    // Halfword lane depends only on offset[1]; a misaligned bit 0 is ignored.
    half_sel = offset[1] ? raw[31:16] : raw[15:0];
  end

  // Extension; reserved size falls through to a full word.
  always_comb begin
    data = raw;
    case (size)
      LS_B: data = {{(DATA_WIDTH-8){~zero_ext & byte_sel[7]}}, byte_sel};
      LS_H: data = {{(DATA_WIDTH-16){~zero_ext & half_sel[15]}}, half_sel};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/rv32_writeback.sv
// RV32I writeback stage: MEM/WB pipeline register, result select/alignment,
// register-file write port driver and retired-instruction counter.
// Ports:
//   clk, async_rst      clock (rising edge) and async active-high reset
//   mem_*               MEM-stage instruction fields
//   stall / flush       hold / bubble the MEM/WB register (flush wins)
//   write_enable/addr/data  register-file write port (flop-driven)
//   retired_count       instructions retired since reset
module rv32_writeback
  import rv32_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  async_rst,
  input  logic                  mem_valid,
  input  logic                  mem_rd_we,
  input  logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [1:0]            mem_wb_sel,
  input  logic [DATA_WIDTH-1:0] mem_alu_result,
  input  logic [DATA_WIDTH-1:0] mem_load_data,
  input  logic [1:0]            mem_load_size,
  input  logic                  mem_load_unsigned,
  input  logic [DATA_WIDTH-1:0] mem_pc_plus4,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [CNT_WIDTH-1:0]  retired_count
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] load_c;
  logic [DATA_WIDTH-1:0] result_c;
  logic                  we_c;

  rv32_load_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_align (
    .raw      (mem_load_data),
    .offset   (mem_alu_result[1:0]),
    .size     (mem_load_size),
    .zero_ext (mem_load_unsigned),
    .data     (load_c)
  );

  // Result select ahead of the pipeline register; reserved select yields 0.
  always_comb begin
    result_c = '0;
    case (mem_wb_sel)
      WB_ALU:  result_c = mem_alu_result;
      WB_LOAD: result_c = load_c;
      WB_PC4:  result_c = mem_pc_plus4;
      default: result_c = '0;
    endcase
  end

  // Write strobe precomputed so write_enable comes straight from a flop.
  assign we_c = mem_valid & mem_rd_we & (mem_rd_addr != '0);

  // MEM/WB register: flush beats stall beats capture.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      valid_q      <= 1'b0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else if (flush) begin
      valid_q      <= 1'b0;
      write_enable <= 1'b0;
    end else if (!stall) begin
      valid_q      <= mem_valid;
      write_enable <= we_c;
      write_addr   <= mem_rd_addr;
      write_data   <= result_c;
    end
  end

  // An instruction retires when it leaves MEM/WB; a flush does not cancel it.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      retired_count <= '0;
    end else if (valid_q && !stall) begin
      retired_count <= retired_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_rv32_writeback.sv
// Directed bench for rv32_writeback with hand-computed expectations.
module tb_rv32_writeback;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        async_rst;
  logic        mem_valid, mem_rd_we;
  logic [4:0]  mem_rd_addr;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus4;
  logic [1:0]  mem_load_size;
  logic        mem_load_unsigned;
  logic        stall, flush;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [63:0] retired_count;

  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;
  logic [63:0] exp_cnt = '0;
  logic        v_model = 1'b0;

  rv32_writeback dut (
    .clk               (clk),
    .async_rst         (async_rst),
    .mem_valid         (mem_valid),
    .mem_rd_we         (mem_rd_we),
    .mem_rd_addr       (mem_rd_addr),
    .mem_wb_sel        (mem_wb_sel),
    .mem_alu_result    (mem_alu_result),
    .mem_load_data     (mem_load_data),
    .mem_load_size     (mem_load_size),
    .mem_load_unsigned (mem_load_unsigned),
    .mem_pc_plus4      (mem_pc_plus4),
    .stall             (stall),
    .flush             (flush),
    .write_enable      (write_enable),
    .write_addr        (write_addr),
    .write_data        (write_data),
    .retired_count     (retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [1:0] sz,
                       input logic uns, input logic [31:0] pc4);
    mem_valid = v; mem_rd_we = we; mem_rd_addr = rd; mem_wb_sel = sel;
    mem_alu_result = alu; mem_load_data = ld; mem_load_size = sz;
    mem_load_unsigned = uns; mem_pc_plus4 = pc4;
  endtask

  // Advance one rising edge and track the expected retire count.
  task automatic step();
    logic retire;
    retire = v_model && !stall;
    @(posedge clk);
    #1;
    if (retire) exp_cnt = exp_cnt + 64'd1;
    if (flush)       v_model = 1'b0;
    else if (!stall) v_model = mem_valid;
  endtask

  task automatic check_wb(input string tag, input logic we, input logic [4:0] a,
                          input logic [31:0] d);
    check({tag, ".we"}, 64'(write_enable), 64'(we));
    check({tag, ".addr"}, 64'(write_addr), 64'(a));
    check({tag, ".data"}, 64'(write_data), 64'(d));
    check({tag, ".cnt"}, retired_count, exp_cnt);
  endtask

  // Load-alignment vectors: offset, size, unsigned, expected.
  localparam int NLD = 8;
  logic [1:0]  ld_off [NLD] = '{2'd3, 2'd3, 2'd2, 2'd3, 2'd1, 2'd0, 2'd1, 2'd0};
  logic [1:0]  ld_sz  [NLD] = '{LS_B, LS_B, LS_H, LS_H, LS_W, LS_B, LS_B, LS_H};
  logic        ld_uns [NLD] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] ld_exp [NLD] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF,
                                32'h80FF7F01, 32'h00000001, 32'h0000007F, 32'h00007F01};

  initial begin
    async_rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, WB_ALU, 0, 0, LS_W, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_wb("reset", 0, 0, 0);
    async_rst = 1'b0;

    // ALU write to x5.
    drive(1, 1, 5'd5, WB_ALU, 32'h1234, 0, LS_W, 0, 0);
    step();
    check_wb("alu", 1, 5'd5, 32'h1234);
    drive(0, 0, 0, WB_ALU, 0, 0, LS_W, 0, 0);
    step();
    check("alu.retired", retired_count, 64'd1);

    // Load alignment and extension.
    for (int i = 0; i < NLD; i++) begin
      drive(1, 1, 5'd2, WB_LOAD, {30'h400, ld_off[i]}, 32'h80FF7F01, ld_sz[i], ld_uns[i], 0);
      step();
      check_wb($sformatf("load%0d", i), 1, 5'd2, ld_exp[i]);
    end

    // Write to x0 is suppressed but still retires.
    drive(1, 1, 5'd0, WB_ALU, 32'h55, 0, LS_W, 0, 0);
    step();
    check_wb("x0", 0, 0, 32'h55);

    // Stall holds rd=7/0xA5 for three cycles.
    drive(1, 1, 5'd7, WB_ALU, 32'hA5, 0, LS_W, 0, 0);
    step();
    check_wb("pre_stall", 1, 5'd7, 32'hA5);
    drive(1, 1, 5'd9, WB_ALU, 32'h77, 0, LS_W, 0, 0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_wb($sformatf("stall%0d", i), 1, 5'd7, 32'hA5);
    end
    stall = 1'b0;
    step();
    check_wb("unstall", 1, 5'd9, 32'h77);

    // Flush and stall together insert a bubble, no retire.
    flush = 1'b1; stall = 1'b1;
    step();
    check_wb("flush_stall", 0, 5'd9, 32'h77);
    flush = 1'b0; stall = 1'b0;
    step();
    check_wb("refill", 1, 5'd9, 32'h77);
    // Flush alone still retires the held instruction.
    flush = 1'b1;
    step();
    check_wb("flush", 0, 5'd9, 32'h77);
    flush = 1'b0;

    // JAL link value, then reserved select.
    drive(1, 1, 5'd1, WB_PC4, 32'hDEAD, 0, LS_W, 0, 32'h104);
    step();
    check_wb("jal", 1, 5'd1, 32'h104);
    drive(1, 1, 5'd3, 2'd3, 32'hDEAD, 32'hBEEF, LS_W, 0, 32'h104);
    step();
    check_wb("sel3", 1, 5'd3, 32'h0);

    // Asynchronous reset between edges clears everything immediately.
    #3;
    async_rst = 1'b1;
    #1;
    exp_cnt = '0; v_model = 1'b0;
    check_wb("async_rst", 0, 0, 0);
    @(negedge clk);
    async_rst = 1'b0;
    drive(1, 1, 5'd4, WB_ALU, 32'h42, 0, LS_W, 0, 0);
    step();
    check_wb("post_rst", 1, 5'd4, 32'h42);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
